pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter FWD_EN, default 1, meaning 1 = forwarding present so only load-use stalls; 0 = no forwarding so every RAW hazard stalls.
REQ-002 Parameter CNT_W, default 32, meaning width of each performance counter.
REQ-003 Parameter RID_W, default 4, meaning register-ID width; RNONE is all-ones.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 Ports D_icode, E_icode, M_icode, W_icode, input, 4 each, stage icodes.
REQ-007 Ports d_srcA, d_srcB, E_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM, input, RID_W each, register IDs.
REQ-008 Port e_cnd, input, 1, branch condition from execute.
REQ-009 Ports m_stat, W_stat, input, 4 each, status codes (AOK=1, HLT=2, ADR=3, INS=4).
REQ-010 Ports F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, output, 1 each, pipeline control.
REQ-011 Ports halted, err, output, 1 each, registered run status.
REQ-012 Ports cycle_cnt, retire_cnt, stall_cnt, output, CNT_W each, performance counters.

Function
REQ-013 Control outputs SHALL be combinational from current inputs and state, valid in the same cycle.
REQ-014 load_use SHALL be E_icode in {MRMOVQ=5, POPQ=B}, with E_dstM != RNONE and E_dstM equal to d_srcA or d_srcB.
REQ-015 When FWD_EN=0, raw SHALL be any non-RNONE d_srcA or d_srcB matching any of E_dstE, E_dstM, M_dstE, M_dstM, W_dstE or W_dstM; when FWD_EN=1, raw SHALL be 0.
REQ-016 data_haz SHALL be load_use OR raw.
REQ-017 ret_haz SHALL be RET (9) present in D_icode, E_icode or M_icode.
REQ-018 mispred SHALL be E_icode=JXX (7) AND NOT e_cnd.
REQ-019 In RUN: F_stall = data_haz|ret_haz; D_stall = data_haz; D_bubble = mispred|(ret_haz&~data_haz); E_bubble = mispred|data_haz.
REQ-020 exc SHALL be status not AOK; in RUN, M_bubble = exc(m_stat)|exc(W_stat) and W_stall = exc(W_stat).
REQ-021 set_cc SHALL be E_icode=OPQ (6) AND m_stat=AOK AND W_stat=AOK, and 0 outside RUN.
REQ-022 The state machine SHALL have states RUN and HALTED; RUN goes to HALTED when W_stat != AOK; HALTED exits only via reset.
REQ-023 On entering HALTED, err SHALL latch 1 if W_stat is ADR or INS and 0 if HLT.
REQ-024 In HALTED: F_stall = D_stall = W_stall = 1; all bubbles = 0; halted = 1 from the cycle after the triggering edge.
REQ-025 Combined hazards SHALL follow REQ-019 without extra priority logic: mispred+ret gives F stall, D bubble, E bubble; load_use+ret gives F stall, D stall, E bubble.
REQ-026 In RUN, cycle_cnt SHALL increment every cycle.
REQ-027 In RUN, retire_cnt SHALL increment when W_stat=AOK and W_icode != NOP (1).
REQ-028 In RUN, stall_cnt SHALL increment when F_stall=1.
REQ-029 All counters SHALL saturate at 2^CNT_W-1 and freeze in HALTED.

Reset
REQ-030 On a clock edge with rst_n=0, state SHALL become RUN and halted, err and all counters SHALL become 0, including mid-HALTED.
REQ-031 Combinational outputs SHALL evaluate as RUN during reset.

Structure
REQ-032 Icode constants, status codes, RNONE and the state enum SHALL live in the shared package y86_pkg.
REQ-033 One sub-module, perf_counter (saturating, enable input, CNT_W parameter), SHALL be instantiated three times.

Verification
REQ-034 Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1.
REQ-035 Mispredict: E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; with e_cnd=1 -> all 0.
REQ-036 FWD_EN=0: d_srcB=2, W_dstE=2, E_icode=6 -> F_stall=1, D_stall=1, E_bubble=1; same stimulus with FWD_EN=1 -> no stall.
REQ-037 Ret plus load-use: D_icode=9, E_icode=B, E_dstM=4, d_srcA=4 -> F_stall=1, D_stall=1, D_bubble=0, E_bubble=1.
REQ-038 W_stat=3 for one cycle -> next cycle halted=1, err=1, counters frozen; rst_n=0 for one edge -> halted=0, counters 0.
REQ-039 CNT_W=4: run 20 cycles -> cycle_cnt=15 (saturated); 6 non-NOP AOK retirements -> retire_cnt=6.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 pipeline encodings: icodes, status codes, the null register ID and
// the hazard-controller run state.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] S_AOK = 4'h1;
   localparam logic [3:0] S_HLT = 4'h2;
   localparam logic [3:0] S_ADR = 4'h3;
   localparam logic [3:0] S_INS = 4'h4;

   // All-ones; users slice it down to their register-ID width
   localparam logic [31:0] RNONE = 32'hFFFF_FFFF;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } hz_state_e;

endpackage

// File: rtl/perf_counter.sv
// Saturating up-counter with enable and synchronous active-low reset.
module perf_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86 pipeline hazard controller: stall/bubble generation, halt tracking and
// saturating performance counters.
module pipe_hazard_ctrl
   import y86_pkg::*;
#(
   parameter int unsigned FWD_EN = 1,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned RID_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       W_icode,
   input  logic [RID_W-1:0] d_srcA,
   input  logic [RID_W-1:0] d_srcB,
   input  logic [RID_W-1:0] E_dstE,
   input  logic [RID_W-1:0] E_dstM,
   input  logic [RID_W-1:0] M_dstE,
   input  logic [RID_W-1:0] M_dstM,
   input  logic [RID_W-1:0] W_dstE,
   input  logic [RID_W-1:0] W_dstM,
   input  logic             e_cnd,
   input  logic [3:0]       m_stat,
   input  logic [3:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_cc,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [RID_W-1:0] RID_NONE = RNONE[RID_W-1:0];

   hz_state_e state_q;
   hz_state_e state_d;
   logic      err_q;
   logic      err_d;

   logic load_use;
   logic raw;
   logic data_haz;
   logic ret_haz;
   logic mispred;
   logic exc_m;
   logic exc_w;
   logic run_c;
   logic in_run;
   logic cyc_en;
   logic ret_en;
   logic stl_en;

   // A source operand depends on any in-flight destination write
   function automatic logic src_hit(input logic [RID_W-1:0] src,
                                    input logic [RID_W-1:0] e_de, input logic [RID_W-1:0] e_dm,
                                    input logic [RID_W-1:0] m_de, input logic [RID_W-1:0] m_dm,
                                    input logic [RID_W-1:0] w_de, input logic [RID_W-1:0] w_dm);
      return (src != RID_NONE) &&
             ((src == e_de) || (src == e_dm) || (src == m_de) ||
              (src == m_dm) || (src == w_de) || (src == w_dm));
   endfunction

   always_comb begin
      load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                 (E_dstM != RID_NONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      raw = 1'b0;
      if (FWD_EN == 0) begin
         raw = src_hit(d_srcA, E_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM) ||
               src_hit(d_srcB, E_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM);
      end
      data_haz = load_use || raw;
      ret_haz  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
      mispred  = (E_icode == I_JXX) && !e_cnd;
      exc_m    = (m_stat != S_AOK);
      exc_w    = (W_stat != S_AOK);
   end

   // Reset forces the RUN view so downstream stages see live hazard controls
   assign run_c  = (state_q == RUN) || !rst_n;
   assign in_run = (state_q == RUN);

   always_comb begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b1;
      set_cc   = 1'b0;
      if (run_c) begin
         F_stall  = data_haz || ret_haz;
         D_stall  = data_haz;
         D_bubble = mispred || (ret_haz && !data_haz);
         E_bubble = mispred || data_haz;
         M_bubble = exc_m || exc_w;
         W_stall  = exc_w;
         set_cc   = (E_icode == I_OPQ) && !exc_m && !exc_w;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      if ((state_q == RUN) && exc_w) begin
         state_d = HALTED;
         err_d   = (W_stat == S_ADR) || (W_stat == S_INS);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   assign halted = (state_q == HALTED);
   assign err    = err_q;

   assign cyc_en = in_run;
   assign ret_en = in_run && !exc_w && (W_icode != I_NOP);
   assign stl_en = in_run && F_stall;

   perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cyc_en),
      .cnt   (cycle_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_retire_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ret_en),
      .cnt   (retire_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (stl_en),
      .cnt   (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, no-forwarding and 4-bit
// counter instances share one stimulus set.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic       rst4_n;
   logic [3:0] D_icode, E_icode, M_icode, W_icode;
   logic [3:0] d_srcA, d_srcB, E_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM;
   logic       e_cnd;
   logic [3:0] m_stat, W_stat;

   logic        fs1, ds1, db1, eb1, mb1, ws1, cc1, halted1, err1;
   logic [31:0] cyc1, ret1, stl1;
   logic        fs0, ds0, db0, eb0, mb0, ws0, cc0, halted0, err0;
   logic [31:0] cyc0, ret0, stl0;
   logic        fs4, ds4, db4, eb4, mb4, ws4, cc4, halted4, err4;
   logic [3:0]  cyc4, ret4, stl4;

   logic [6:0] ctrl1, ctrl0;
   assign ctrl1 = {fs1, ds1, db1, eb1, mb1, ws1, cc1};
   assign ctrl0 = {fs0, ds0, db0, eb0, mb0, ws0, cc0};

   int n_checks;
   int n_fail;

   pipe_hazard_ctrl #(.FWD_EN(1), .CNT_W(32), .RID_W(4)) u_fwd1 (
      .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
      .W_icode(W_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM), .e_cnd(e_cnd),
      .m_stat(m_stat), .W_stat(W_stat), .F_stall(fs1), .D_stall(ds1), .D_bubble(db1),
      .E_bubble(eb1), .M_bubble(mb1), .W_stall(ws1), .set_cc(cc1), .halted(halted1),
      .err(err1), .cycle_cnt(cyc1), .retire_cnt(ret1), .stall_cnt(stl1));

   pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(32), .RID_W(4)) u_fwd0 (
      .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
      .W_icode(W_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM), .e_cnd(e_cnd),
      .m_stat(m_stat), .W_stat(W_stat), .F_stall(fs0), .D_stall(ds0), .D_bubble(db0),
      .E_bubble(eb0), .M_bubble(mb0), .W_stall(ws0), .set_cc(cc0), .halted(halted0),
      .err(err0), .cycle_cnt(cyc0), .retire_cnt(ret0), .stall_cnt(stl0));

   pipe_hazard_ctrl #(.FWD_EN(1), .CNT_W(4), .RID_W(4)) u_cnt4 (
      .clk(clk), .rst_n(rst4_n), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
      .W_icode(W_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM), .e_cnd(e_cnd),
      .m_stat(m_stat), .W_stat(W_stat), .F_stall(fs4), .D_stall(ds4), .D_bubble(db4),
      .E_bubble(eb4), .M_bubble(mb4), .W_stall(ws4), .set_cc(cc4), .halted(halted4),
      .err(err4), .cycle_cnt(cyc4), .retire_cnt(ret4), .stall_cnt(stl4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstE = 4'hF; E_dstM = 4'hF;
      M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
      e_cnd = 1'b1; m_stat = 4'h1; W_stat = 4'h1;
   endtask

   // One rising edge, then return on the following falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst4_n = 1'b0;
      set_idle();
      step(); step();
      #1;
      n_checks++;
      if (ctrl1 !== 7'b0000000) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl1, 7'b0000000); end
      n_checks++;
      if ({halted1, err1} !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b want 00", {halted1, err1}); end
      n_checks++;
      if ({cyc1, ret1, stl1} !== 96'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0", cyc1, ret1, stl1); end
      @(negedge clk);
      rst_n = 1'b1; rst4_n = 1'b1;
   endtask

   task automatic test_load_use();
      logic [31:0] s0;
      s0 = stl1;
      E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
      #1;
      n_checks++;
      if (ctrl1 !== 7'b1101000) begin n_fail++; $display("FAIL load_use_fwd1: got %b want %b", ctrl1, 7'b1101000); end
      n_checks++;
      if (ctrl0 !== 7'b1101000) begin n_fail++; $display("FAIL load_use_fwd0: got %b want %b", ctrl0, 7'b1101000); end
      step();
      n_checks++;
      if (stl1 !== s0 + 32'd1) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d want %0d", stl1, s0 + 32'd1); end
      set_idle();
   endtask

   task automatic test_mispred();
      E_icode = 4'h7; e_cnd = 1'b0;
      #1;
      n_checks++;
      if (ctrl1 !== 7'b0011000) begin n_fail++; $display("FAIL mispred_taken: got %b want %b", ctrl1, 7'b0011000); end
      e_cnd = 1'b1;
      #1;
      n_checks++;
      if (ctrl1 !== 7'b0000000) begin n_fail++; $display("FAIL mispred_correct: got %b want %b", ctrl1, 7'b0000000); end
      step();
      set_idle();
   endtask

   task automatic test_raw();
      E_icode = 4'h6; d_srcB = 4'h2; W_dstE = 4'h2;
      #1;
      n_checks++;
      if (ctrl0 !== 7'b1101001) begin n_fail++; $display("FAIL raw_fwd0: got %b want %b", ctrl0, 7'b1101001); end
      n_checks++;
      if (ctrl1 !== 7'b0000001) begin n_fail++; $display("FAIL raw_fwd1: got %b want %b", ctrl1, 7'b0000001); end
      step();
      set_idle();
   endtask

   task automatic test_combined();
      D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4;
      #1;
      n_checks++;
      if (ctrl1 !== 7'b1101000) begin n_fail++; $display("FAIL ret_load_use: got %b want %b", ctrl1, 7'b1101000); end
      step();
      set_idle();
      D_icode = 4'h9; E_icode = 4'h7; e_cnd = 1'b0;
      #1;
      n_checks++;
      if (ctrl1 !== 7'b1011000) begin n_fail++; $display("FAIL ret_mispred: got %b want %b", ctrl1, 7'b1011000); end
      step();
      set_idle();
      m_stat = 4'h4;
      #1;
      n_checks++;
      if (ctrl1 !== 7'b0000100) begin n_fail++; $display("FAIL mem_exc: got %b want %b", ctrl1, 7'b0000100); end
      step();
      n_checks++;
      if (halted1 !== 1'b0) begin n_fail++; $display("FAIL mem_exc_no_halt: got %b want 0", halted1); end
      set_idle();
   endtask

   task automatic test_saturation();
      rst4_n = 1'b0;
      step();
      rst4_n = 1'b1;
      W_icode = 4'h6;
      repeat (6) step();
      n_checks++;
      if ({cyc4, ret4} !== {4'd6, 4'd6}) begin n_fail++; $display("FAIL cnt4_mid: got cyc %0d ret %0d want 6 6", cyc4, ret4); end
      W_icode = 4'h1;
      repeat (14) step();
      n_checks++;
      if (cyc4 !== 4'd15) begin n_fail++; $display("FAIL cnt4_cycle_sat: got %0d want 15", cyc4); end
      n_checks++;
      if ({ret4, stl4} !== {4'd6, 4'd0}) begin n_fail++; $display("FAIL cnt4_retire: got ret %0d stall %0d want 6 0", ret4, stl4); end
   endtask

   task automatic test_halt();
      logic [31:0] c0, r0, s0;
      c0 = cyc1; r0 = ret1; s0 = stl1;
      W_stat = 4'h3;
      #1;
      n_checks++;
      if (ctrl1 !== 7'b0000110) begin n_fail++; $display("FAIL wb_exc_ctrl: got %b want %b", ctrl1, 7'b0000110); end
      n_checks++;
      if (halted1 !== 1'b0) begin n_fail++; $display("FAIL halted_early: got %b want 0", halted1); end
      step();
      set_idle();
      E_icode = 4'h7; e_cnd = 1'b0;
      #1;
      n_checks++;
      if ({halted1, err1} !== 2'b11) begin n_fail++; $display("FAIL halt_adr: got %b want 11", {halted1, err1}); end
      n_checks++;
      if (ctrl1 !== 7'b1100010) begin n_fail++; $display("FAIL halted_ctrl: got %b want %b", ctrl1, 7'b1100010); end
      E_icode = 4'h6; W_icode = 4'h6;
      #1;
      n_checks++;
      if (ctrl1 !== 7'b1100010) begin n_fail++; $display("FAIL halted_set_cc: got %b want %b", ctrl1, 7'b1100010); end
      repeat (3) step();
      n_checks++;
      if ({cyc1, ret1, stl1} !== {c0 + 32'd1, r0, s0}) begin
         n_fail++;
         $display("FAIL halted_frozen: got %0d %0d %0d want %0d %0d %0d", cyc1, ret1, stl1, c0 + 32'd1, r0, s0);
      end
      set_idle();
      E_icode = 4'h7; e_cnd = 1'b0; rst_n = 1'b0;
      #1;
      n_checks++;
      if (ctrl1 !== 7'b0011000) begin n_fail++; $display("FAIL reset_view_run: got %b want %b", ctrl1, 7'b0011000); end
      step();
      rst_n = 1'b1;
      set_idle();
      #1;
      n_checks++;
      if ({halted1, err1} !== 2'b00) begin n_fail++; $display("FAIL reset_from_halt: got %b want 00", {halted1, err1}); end
      n_checks++;
      if ({cyc1, ret1, stl1} !== 96'd0) begin n_fail++; $display("FAIL reset_from_halt_cnt: got %0d %0d %0d want 0 0 0", cyc1, ret1, stl1); end
   endtask

   task automatic test_hlt_no_err();
      @(negedge clk);
      W_stat = 4'h2;
      step();
      W_stat = 4'h1;
      #1;
      n_checks++;
      if ({halted1, err1} !== 2'b10) begin n_fail++; $display("FAIL halt_hlt: got %b want 10", {halted1, err1}); end
      @(negedge clk);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (halted1 !== 1'b0) begin n_fail++; $display("FAIL halt_hlt_cleared: got %b want 0", halted1); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      @(negedge clk);
      test_load_use();
      test_mispred();
      test_raw();
      test_combined();
      test_saturation();
      test_halt();
      test_hlt_no_err();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
